// File: rtl/rgb_filter_pkg.sv
// Shared types and constants for the RGB on/off filter controller.
package rgb_filter_pkg;

  localparam int MODE_W    = 3;
  localparam int NUM_MODES = 8;

  // Channel enables {r,g,b} for each mode index. Element 0 is the leftmost entry.
  localparam logic [0:NUM_MODES-1][2:0] MODE_TABLE = {
    3'b111, 3'b100, 3'b010, 3'b001, 3'b110, 3'b011, 3'b101, 3'b000
  };

  typedef enum logic [0:0] {
    ST_IDLE    = 1'b0,
    ST_PENDING = 1'b1
  } state_e;

  // Look up the {r,g,b} enables for a mode index.
  function automatic logic [2:0] mode_rgb(input logic [MODE_W-1:0] idx);
    return MODE_TABLE[idx];
  endfunction

  // Step a mode index forward or back; the index width gives the mod-8 wrap.
  function automatic logic [MODE_W-1:0] step_idx(input logic [MODE_W-1:0] base,
                                                 input logic              fwd);
    return fwd ? (base + MODE_W'(1)) : (base - MODE_W'(1));
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// Button conditioner: 2-FF synchronizer, hold-time debounce and press pulse.
// A button already held when reset releases is ignored until it has been
// seen released, so a held button cannot fake a press after reset.
module btn_debounce #(
  parameter int DEBOUNCE_CYC = 1_000_000
) (
  input  logic clk,
  input  logic reset_n,
  input  logic btn,
  output logic press
);

  localparam int CNT_W = (DEBOUNCE_CYC > 1) ? $clog2(DEBOUNCE_CYC) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYC - 1);

  logic             sync1_r;
  logic             sync2_r;
  logic [1:0]       prime_r;
  logic             stable_r;
  logic [CNT_W-1:0] cnt_r;
  logic             armed_r;
  logic             press_r;
  logic             accept_s;

  assign accept_s = (sync2_r != stable_r) && (cnt_r == CNT_LAST);

  // Synchronize the raw button and track when the synchronizer output is valid.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1_r <= 1'b0;
      sync2_r <= 1'b0;
      prime_r <= 2'b00;
    end else begin
      sync1_r <= btn;
      sync2_r <= sync1_r;
      prime_r <= {prime_r[0], 1'b1};
    end
  end

  // Count cycles of disagreement and accept the new level once it has held.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_r    <= '0;
      stable_r <= 1'b0;
    end else if (sync2_r == stable_r) begin
      cnt_r    <= '0;
      stable_r <= stable_r;
    end else if (accept_s) begin
      cnt_r    <= '0;
      stable_r <= sync2_r;
    end else begin
      cnt_r    <= cnt_r + CNT_W'(1);
      stable_r <= stable_r;
    end
  end

  // Arm once a released button is seen, then pulse on each accepted 0->1 change.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      armed_r <= 1'b0;
      press_r <= 1'b0;
    end else begin
      if (prime_r[1] && !sync2_r && !stable_r) begin
        armed_r <= 1'b1;
      end else begin
        armed_r <= armed_r;
      end
      press_r <= accept_s && sync2_r && armed_r;
    end
  end

  assign press = press_r;

endmodule

// File: rtl/rgb_filter_ctrl.sv
// RGB filter mode controller: buttons request a mode, vsync applies it.
module rgb_filter_ctrl
  import rgb_filter_pkg::*;
#(
  parameter int DEBOUNCE_CYC = 1_000_000
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              btn_next,
  input  logic              btn_prev,
  input  logic              vsync,
  output logic              sw_r,
  output logic              sw_g,
  output logic              sw_b,
  output logic [MODE_W-1:0] o_mode_idx,
  output logic              o_pending
);

  logic              press_next_s;
  logic              press_prev_s;
  logic              press_any_s;
  logic              vs_sync1_r;
  logic              vs_sync2_r;
  logic              vs_prev_r;
  logic              vs_edge_s;
  state_e            state_r;
  state_e            state_next_s;
  logic [MODE_W-1:0] req_idx_r;
  logic [MODE_W-1:0] req_next_s;
  logic [MODE_W-1:0] applied_r;
  logic [MODE_W-1:0] applied_next_s;
  logic [2:0]        sw_rgb_r;

  btn_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_deb_next (
    .clk     (clk),
    .reset_n (reset_n),
    .btn     (btn_next),
    .press   (press_next_s)
  );

  btn_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_deb_prev (
    .clk     (clk),
    .reset_n (reset_n),
    .btn     (btn_prev),
    .press   (press_prev_s)
  );

  // Simultaneous next and prev presses cancel each other.
  assign press_any_s = press_next_s ^ press_prev_s;
  assign vs_edge_s   = vs_sync2_r & ~vs_prev_r;

  // Synchronize vsync and keep its previous value for rising-edge detection.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      vs_sync1_r <= 1'b0;
      vs_sync2_r <= 1'b0;
      vs_prev_r  <= 1'b0;
    end else begin
      vs_sync1_r <= vsync;
      vs_sync2_r <= vs_sync1_r;
      vs_prev_r  <= vs_sync2_r;
    end
  end

  // Next-state logic: a frame edge applies the request held before any same-cycle press.
  always_comb begin
    state_next_s   = state_r;
    req_next_s     = req_idx_r;
    applied_next_s = applied_r;
    case (state_r)
      ST_IDLE: begin
        if (press_any_s) begin
          req_next_s   = step_idx(applied_r, press_next_s);
          state_next_s = ST_PENDING;
        end else begin
          state_next_s = ST_IDLE;
        end
      end
      ST_PENDING: begin
        if (vs_edge_s) begin
          applied_next_s = req_idx_r;
        end else begin
          applied_next_s = applied_r;
        end
        if (press_any_s) begin
          req_next_s   = step_idx(req_idx_r, press_next_s);
          state_next_s = ST_PENDING;
        end else if (vs_edge_s) begin
          state_next_s = ST_IDLE;
        end else begin
          state_next_s = ST_PENDING;
        end
      end
      default: begin
        state_next_s = ST_IDLE;
      end
    endcase
  end

  // State, request, applied mode and channel enables all update on one edge.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r   <= ST_IDLE;
      req_idx_r <= '0;
      applied_r <= '0;
      sw_rgb_r  <= 3'b111;
    end else begin
      state_r   <= state_next_s;
      req_idx_r <= req_next_s;
      applied_r <= applied_next_s;
      sw_rgb_r  <= mode_rgb(applied_next_s);
    end
  end

  assign sw_r       = sw_rgb_r[2];
  assign sw_g       = sw_rgb_r[1];
  assign sw_b       = sw_rgb_r[0];
  assign o_mode_idx = applied_r;
  assign o_pending  = (state_r == ST_PENDING);

endmodule

// File: doc/rgb_filter_ctrl.md
RGB_FILTER_CTRL -- requirements
Module: rgb_filter_ctrl

Interface
REQ-001 Parameter DEBOUNCE_CYC, default 1_000_000: cycles a synchronized button level must hold before it is accepted (10 ms at 100 MHz).
REQ-002 clk  input  1  single system clock; all state updates on the rising edge.
REQ-003 reset_n  input  1  asynchronous, active-low reset.
REQ-004 btn_next  input  1  raw, asynchronous, active-high button; advances the channel mode.
REQ-005 btn_prev  input  1  raw, asynchronous, active-high button; steps the channel mode back.
REQ-006 vsync  input  1  asynchronous frame-boundary level; a rising edge marks a frame start.
REQ-007 sw_r, sw_g, sw_b  output  1 each  registered channel enables driving the RGB on/off filter.
REQ-008 o_mode_idx  output  3  index of the applied mode.
REQ-009 o_pending  output  1  high while a requested mode waits for a frame boundary.

Function
REQ-010 Mode table, index 0..7, {r,g,b}: 111, 100, 010, 001, 110, 011, 101, 000.
REQ-011 btn_next, btn_prev and vsync each pass through a 2-FF synchronizer before any use.
REQ-012 Debounce: a per-button counter clears whenever the synchronized level equals the stable level, and increments otherwise.
REQ-013 When the counter reaches DEBOUNCE_CYC-1 while the levels still differ, the stable level takes the synchronized level and the counter clears.
REQ-014 A press is a single-cycle pulse on the 0->1 transition of the stable level; releases produce no event.
REQ-015 FSM states are IDLE and PENDING, with a pending index register req_idx.
REQ-016 IDLE + next press: req_idx = (applied+1) mod 8 -> PENDING.
REQ-017 IDLE + prev press: req_idx = (applied-1) mod 8 (0 wraps to 7) -> PENDING.
REQ-018 PENDING + press: req_idx steps from req_idx by the same mod-8 rule; the latest request wins and no event is queued.
REQ-019 Next and prev presses in the same cycle cancel; nothing changes.
REQ-020 A vsync rising edge (synchronized value 1, previous value 0) in PENDING loads applied = req_idx and updates sw_* and o_mode_idx in the same clock edge -> IDLE.
REQ-021 When a press and a vsync edge occur in the same cycle while PENDING, the edge applies the pre-press req_idx; the press then updates req_idx and the FSM stays PENDING.
REQ-022 A vsync edge in IDLE has no effect.
REQ-023 Latency from a raw vsync rise to a sw_* change is 3 clock edges: 2 synchronizer stages plus the registered update.
REQ-024 A request equal to the applied index still passes through PENDING and is applied (no-op) at the next edge.
REQ-025 o_pending = (state == PENDING); sw_* change only at frame boundaries, never mid-frame.

Reset
REQ-026 reset_n low asynchronously forces: applied = 0 (sw_r = sw_g = sw_b = 1), o_mode_idx = 0, req_idx = 0, state = IDLE, o_pending = 0.
REQ-027 Reset also clears all synchronizer flops, debounce counters, stable levels and the vsync previous-value flop to 0.
REQ-028 Reset asserted mid-debounce or while PENDING discards the request; after release, no press event is generated for a button that is already held until it is released and pressed again.

Structure
REQ-029 Package rgb_filter_pkg holds the mode-table constant (8 x 3 bits), the FSM state enum, and a MODE_W = 3 constant.
REQ-030 Sub-module btn_debounce (synchronizer, counter, stable level, press pulse; DEBOUNCE_CYC parameter) is instantiated once per button.

Verification (DEBOUNCE_CYC = 4)
REQ-031 Reset release with no inputs -> sw = 111, o_mode_idx = 0, o_pending = 0 held for 100 cycles.
REQ-032 btn_next high 3 cycles then low (a glitch) -> no press, o_pending stays 0; btn_next high 10 cycles -> o_pending = 1, sw unchanged; vsync rise -> 3 edges later sw = 100, o_mode_idx = 1, o_pending = 0.
REQ-033 From index 0, one prev press then a vsync rise -> o_mode_idx = 7, sw = 000 (wrap-around).
REQ-034 Three next presses before any vsync -> a single vsync rise applies index 3, sw = 001; a second vsync rise changes nothing.
REQ-035 Next and prev stable-rise in the same cycle -> o_pending stays 0 and the index is unchanged.
REQ-036 Reset_n pulsed low while PENDING at req_idx 2 -> sw = 111, o_pending = 0; a later vsync rise keeps index 0.
